// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and helpers for the RAM port arbiter.
//   DEF_*      : default geometry of the RAM this arbiter is normally paired with
//   id_width() : bits needed to encode a requester index (at least 1)
//   inflight_t : one tracking-pipeline stage {valid, id, is_read}
package ram_arb_pkg;
  localparam int MAX_REQ    = 8;
  localparam int MAX_ID_W   = 3;
  localparam int DEF_DEPTH  = 16384;
  localparam int DEF_ADDR_W = $clog2(DEF_DEPTH);
  localparam int DEF_DATA_W = 4 * 8;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // id is sized for the largest supported requester count so the struct
  // needs no parameterization; unused upper bits stay zero.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                is_read;
  } inflight_t;
endpackage

// File: rtl/ram_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker.
//   req    : request vector
//   ptr    : first index to consider; search wraps N_REQ-1 -> 0
//   mask   : eligible requesters (all ones, or only the lock owner)
//   grant  : one-hot grant (zero when nothing eligible)
//   gnt_id : encoded grant index (zero when nothing eligible)
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic [N_REQ-1:0] mask,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  gnt_id
);
  always_comb begin
    logic found;
    int   idx;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx] && mask[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one block-RAM port between N_REQ requesters.
//   req_*  : per-requester valid/ready request bus (wstrb==0 means read)
//   rsp_*  : per-requester response strobe, shared read data (0 for writes)
//   ram_*  : RAM port (en/we/addr/din out, dout in, LATENCY-cycle reads)
// Round-robin grant with a lock for atomic sequences; a LATENCY-deep
// tracking pipeline steers each response back to its issuer.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int N_REQ     = 2,
  parameter  int RAM_DEPTH = 16384,
  parameter  int COL_WIDTH = 8,
  parameter  int COL_NUM   = 4,
  parameter  int LATENCY   = 1,
  localparam int ADDR_W    = $clog2(RAM_DEPTH),
  localparam int DATA_W    = COL_NUM * COL_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req_valid,
  output logic [N_REQ-1:0]               req_ready,
  input  logic [N_REQ-1:0]               req_lock,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_wdata,
  input  logic [N_REQ-1:0][COL_NUM-1:0]  req_wstrb,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           ram_en,
  output logic [COL_NUM-1:0]             ram_we,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_din,
  input  logic [DATA_W-1:0]              ram_dout
);
  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0]  rr_ptr, lock_owner, gnt_id;
  logic             lock_active, xfer;
  logic [N_REQ-1:0] mask, grant;
  inflight_t        trk_pipe [LATENCY];
  inflight_t        last;

  // While locked only the owner is eligible.
  always_comb begin
    mask = '1;
    if (lock_active) mask = N_REQ'(1) << lock_owner;
  end

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .mask   (mask),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  // Grant only ever covers valid requesters, so any ready bit is a transfer.
  assign req_ready = rst ? '0 : grant;
  assign xfer      = |req_ready;
  assign ram_en    = xfer;
  assign ram_we    = xfer ? req_wstrb[gnt_id] : '0;
  assign ram_addr  = req_addr[gnt_id];
  assign ram_din   = req_wdata[gnt_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      lock_active <= 1'b0;
      lock_owner  <= '0;
    end else if (xfer) begin
      rr_ptr      <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      lock_active <= req_lock[gnt_id];
      lock_owner  <= gnt_id;
    end else if (lock_active && !req_valid[lock_owner]) begin
      // Owner walked away without an unlocking transfer: free the port.
      lock_active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) trk_pipe[s] <= '0;
    end else begin
      trk_pipe[0] <= '{valid: xfer, id: MAX_ID_W'(gnt_id), is_read: ~|req_wstrb[gnt_id]};
      for (int s = 1; s < LATENCY; s++) trk_pipe[s] <= trk_pipe[s-1];
    end
  end

  assign last = trk_pipe[LATENCY-1];

  // Gated by rst so a response due in the reset cycle is dropped too.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      rsp_valid[i] = !rst && last.valid && (last.id == MAX_ID_W'(i));
    rsp_rdata = (!rst && last.valid && last.is_read) ? ram_dout : '0;
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench: two arbiters (LATENCY 1 and 2) driven by the same requester
// inputs, each with its own behavioural RAM. Directed table, a LATENCY=2
// burst, then random traffic checked against a transaction-level model.
module tb_ram_port_arbiter;
  localparam int N = 2, DEPTH = 16384, AW = 14, DW = 32, CN = 4;

  logic clk = 1'b0, rst = 1'b1, preload = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]          req_valid, req_lock;
  logic [N-1:0][AW-1:0]  req_addr;
  logic [N-1:0][DW-1:0]  req_wdata;
  logic [N-1:0][CN-1:0]  req_wstrb;

  logic [N-1:0]  ready1, ready2, rv1, rv2;
  logic [DW-1:0] rd1, rd2, din1, din2, dout1, dout2, d2a;
  logic          en1, en2;
  logic [CN-1:0] we1, we2;
  logic [AW-1:0] ad1, ad2;

  ram_port_arbiter #(.N_REQ(N), .RAM_DEPTH(DEPTH), .COL_WIDTH(8), .COL_NUM(CN), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv1), .rsp_rdata(rd1), .ram_en(en1), .ram_we(we1), .ram_addr(ad1),
    .ram_din(din1), .ram_dout(dout1));

  ram_port_arbiter #(.N_REQ(N), .RAM_DEPTH(DEPTH), .COL_WIDTH(8), .COL_NUM(CN), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rv2), .rsp_rdata(rd2), .ram_en(en2), .ram_we(we2), .ram_addr(ad2),
    .ram_din(din2), .ram_dout(dout2));

  function automatic logic [31:0] init_word(input int a);
    if (a == 16) return 32'hDEADBEEF;
    if (a == 5)  return 32'hAABBCCDD;
    return (32'(a) * 32'h9E3779B1) ^ 32'h0F0F1234;
  endfunction

  // Read-first byte-writable RAMs, latency 1 and 2.
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] mem2 [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < DEPTH; a++) mem1[a] <= init_word(a);
    end else if (en1) begin
      dout1 <= mem1[ad1];
      for (int c = 0; c < CN; c++) if (we1[c]) mem1[ad1][c*8 +: 8] <= din1[c*8 +: 8];
    end
  end
  always @(posedge clk) begin
    dout2 <= d2a;
    if (preload) begin
      for (int a = 0; a < DEPTH; a++) mem2[a] <= init_word(a);
    end else if (en2) begin
      d2a <= mem2[ad2];
      for (int c = 0; c < CN; c++) if (we2[c]) mem2[ad2][c*8 +: 8] <= din2[c*8 +: 8];
    end
  end

  // ---------------- reference model ----------------
  typedef struct { int due; int id; logic [31:0] data; } rsp_t;
  rsp_t          q1[$], q2[$];
  logic [31:0]   shadow [DEPTH];
  int            m_ptr, m_owner, cyc;
  bit            m_lock;
  int            checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_rsp(ref rsp_t q[$], output logic [N-1:0] ev, output logic [31:0] ed);
    ev = '0; ed = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (!rst) begin ev[q[0].id] = 1'b1; ed = q[0].data; end
      void'(q.pop_front());
    end
  endtask

  // Compare both DUTs against the model for the current cycle, then advance it.
  task automatic model_check();
    int g;
    logic [N-1:0] er, ev1, ev2;
    logic [31:0]  ed1, ed2;
    g = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i] && (!m_lock || i == m_owner)) g = i;
      end
    er = (g >= 0) ? (N'(1) << g) : '0;
    chk("ready_lat1", ready1, er);
    chk("ready_lat2", ready2, er);
    chk("ram_en", {en2, en1}, {2{g >= 0}});
    if (g >= 0) begin
      chk("ram_we", {we2, we1}, {2{req_wstrb[g]}});
      chk("ram_addr", {ad2, ad1}, {2{req_addr[g]}});
      chk("ram_din", {din2, din1}, {2{req_wdata[g]}});
    end else begin
      chk("ram_we_idle", {we2, we1}, '0);
    end
    exp_rsp(q1, ev1, ed1);
    exp_rsp(q2, ev2, ed2);
    chk("rsp_valid_lat1", rv1, ev1);
    chk("rsp_rdata_lat1", rd1, ed1);
    chk("rsp_valid_lat2", rv2, ev2);
    chk("rsp_rdata_lat2", rd2, ed2);
    if (rst) begin
      q1.delete(); q2.delete();
      m_ptr = 0; m_lock = 0; m_owner = 0;
    end else if (g >= 0) begin
      logic [31:0] old;
      bit rd;
      old = shadow[req_addr[g]];
      rd  = (req_wstrb[g] == '0);
      q1.push_back('{cyc + 1, g, rd ? old : 32'h0});
      q2.push_back('{cyc + 2, g, rd ? old : 32'h0});
      for (int c = 0; c < CN; c++)
        if (req_wstrb[g][c]) shadow[req_addr[g]][c*8 +: 8] = req_wdata[g][c*8 +: 8];
      m_ptr = (g + 1) % N; m_lock = req_lock[g]; m_owner = g;
    end else if (m_lock && !req_valid[m_owner]) begin
      m_lock = 0;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  valid, lock;
    logic [13:0] a0, a1;
    logic [31:0] wd1;
    logic [3:0]  ws1;
    logic [1:0]  er, ev;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [1:0] v, input logic [1:0] l,
                              input logic [13:0] a0, input logic [13:0] a1, input logic [31:0] wd,
                              input logic [3:0] ws, input logic [1:0] er, input logic [1:0] ev,
                              input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.valid = v; t.lock = l; t.a0 = a0; t.a1 = a1; t.wd1 = wd;
    t.ws1 = ws; t.er = er; t.ev = ev; t.ed = ed;
    return t;
  endfunction

  vec_t tbl [28];

  initial begin
    req_valid = '0; req_lock = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    for (int a = 0; a < DEPTH; a++) shadow[a] = init_word(a);
    m_ptr = 0; m_lock = 0; m_owner = 0; cyc = 0;

    // reset
    tbl[0]  = mk(1, 2'b00, 2'b00, 0,     0, 0, 0, 2'b00, 2'b00, 0);
    tbl[1]  = mk(1, 2'b11, 2'b00, 0,     0, 0, 0, 2'b00, 2'b00, 0);
    // single read
    tbl[2]  = mk(0, 2'b01, 2'b00, 14'h10, 0, 0, 0, 2'b01, 2'b00, 0);
    tbl[3]  = mk(0, 2'b00, 2'b00, 0,     0, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF);
    // byte write then read
    tbl[4]  = mk(0, 2'b10, 2'b00, 0, 5, 32'h11223344, 4'b0101, 2'b10, 2'b00, 0);
    tbl[5]  = mk(0, 2'b10, 2'b00, 0, 5, 0, 0, 2'b10, 2'b10, 32'h0);
    tbl[6]  = mk(0, 2'b00, 2'b00, 0, 5, 0, 0, 2'b00, 2'b10, 32'hAA22CC44);
    // contention
    tbl[7]  = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b01, 2'b00, 0);
    tbl[8]  = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b10, 2'b01, 32'hDEADBEEF);
    tbl[9]  = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b01, 2'b10, 32'hAA22CC44);
    tbl[10] = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b10, 2'b01, 32'hDEADBEEF);
    tbl[11] = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b01, 2'b10, 32'hAA22CC44);
    tbl[12] = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b10, 2'b01, 32'hDEADBEEF);
    tbl[13] = mk(0, 2'b00, 2'b00, 14'h10, 5, 0, 0, 2'b00, 2'b10, 32'hAA22CC44);
    // lock held by req1 for three transfers, released by lock=0 transfer
    tbl[14] = mk(0, 2'b10, 2'b10, 14'h10, 5, 0, 0, 2'b10, 2'b00, 0);
    tbl[15] = mk(0, 2'b11, 2'b10, 14'h10, 5, 0, 0, 2'b10, 2'b10, 32'hAA22CC44);
    tbl[16] = mk(0, 2'b11, 2'b10, 14'h10, 5, 0, 0, 2'b10, 2'b10, 32'hAA22CC44);
    tbl[17] = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b10, 2'b10, 32'hAA22CC44);
    tbl[18] = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b01, 2'b10, 32'hAA22CC44);
    tbl[19] = mk(0, 2'b00, 2'b00, 14'h10, 5, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF);
    // reset mid-flight
    tbl[20] = mk(0, 2'b01, 2'b00, 14'h10, 5, 0, 0, 2'b01, 2'b00, 0);
    tbl[21] = mk(1, 2'b00, 2'b00, 14'h10, 5, 0, 0, 2'b00, 2'b00, 0);
    tbl[22] = mk(0, 2'b11, 2'b00, 14'h10, 5, 0, 0, 2'b01, 2'b00, 0);
    tbl[23] = mk(0, 2'b00, 2'b00, 14'h10, 5, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF);
    // lock released because the owner drops valid
    tbl[24] = mk(0, 2'b01, 2'b01, 14'h10, 5, 0, 0, 2'b01, 2'b00, 0);
    tbl[25] = mk(0, 2'b10, 2'b00, 14'h10, 5, 0, 0, 2'b00, 2'b01, 32'hDEADBEEF);
    tbl[26] = mk(0, 2'b10, 2'b00, 14'h10, 5, 0, 0, 2'b10, 2'b00, 0);
    tbl[27] = mk(0, 2'b00, 2'b00, 14'h10, 5, 0, 0, 2'b00, 2'b10, 32'hAA22CC44);

    @(posedge clk); #1;
    preload = 1'b0;

    for (int i = 0; i < 28; i++) begin
      rst = tbl[i].rst; req_valid = tbl[i].valid; req_lock = tbl[i].lock;
      req_addr[0] = tbl[i].a0; req_wdata[0] = '0; req_wstrb[0] = '0;
      req_addr[1] = tbl[i].a1; req_wdata[1] = tbl[i].wd1; req_wstrb[1] = tbl[i].ws1;
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), ready1, tbl[i].er);
      chk($sformatf("tbl%0d_rsp_valid", i), rv1, tbl[i].ev);
      chk($sformatf("tbl%0d_rsp_rdata", i), rd1, tbl[i].ed);
      model_check();
      @(posedge clk); #1;
    end

    // LATENCY=2: four back-to-back reads of addrs 0..3
    rst = 0; req_valid = '0; req_lock = '0; req_wstrb = '0;
    step(); step();
    for (int j = 0; j < 6; j++) begin
      req_valid = (j < 4) ? 2'b01 : 2'b00;
      req_addr[0] = AW'(j);
      @(negedge clk);
      chk($sformatf("lat2_burst%0d_valid", j), rv2, (j >= 2) ? 2'b01 : 2'b00);
      chk($sformatf("lat2_burst%0d_rdata", j), rd2, (j >= 2) ? init_word(j - 2) : 32'h0);
      model_check();
      @(posedge clk); #1;
    end

    // random traffic on a small address window to exercise read-after-write
    for (int t = 0; t < 600; t++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        req_lock[i]  = ($urandom_range(0, 3) == 0);
        req_addr[i]  = AW'($urandom_range(0, 7));
        req_wdata[i] = $urandom;
        req_wstrb[i] = $urandom_range(0, 1) ? CN'($urandom) : '0;
      end
      step();
    end
    rst = 0; req_valid = '0; req_lock = '0;
    for (int t = 0; t < 4; t++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
